// File: rtl/inbuf_fifo_if.sv
// Input-buffer FIFO bus: host write side plus controller read side, flags and error status.
interface inbuf_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              host_inbuf_wr_en;
    logic [DATA_W-1:0] host_inbuf_wr_data;
    logic              inbuf_host_full;
    logic              cntl_inbuf_fifo_rd_rq;
    logic              cntl_inbuf_fifo_mem_en;
    logic              inbuf_fifo_cntl_empty;
    logic [DATA_W-1:0] inbuf_fifo_rd_data;
    logic              inbuf_fifo_rd_data_val;
    logic [ADDR_W:0]   inbuf_fifo_count;
    logic              inbuf_fifo_ovf;
    logic              inbuf_fifo_udf;

    modport master (
        output host_inbuf_wr_en, host_inbuf_wr_data,
        output cntl_inbuf_fifo_rd_rq, cntl_inbuf_fifo_mem_en,
        input  inbuf_host_full, inbuf_fifo_cntl_empty,
        input  inbuf_fifo_rd_data, inbuf_fifo_rd_data_val,
        input  inbuf_fifo_count, inbuf_fifo_ovf, inbuf_fifo_udf
    );

    modport slave (
        input  host_inbuf_wr_en, host_inbuf_wr_data,
        input  cntl_inbuf_fifo_rd_rq, cntl_inbuf_fifo_mem_en,
        output inbuf_host_full, inbuf_fifo_cntl_empty,
        output inbuf_fifo_rd_data, inbuf_fifo_rd_data_val,
        output inbuf_fifo_count, inbuf_fifo_ovf, inbuf_fifo_udf
    );
endinterface

// File: rtl/inbuf_fifo.sv
// Input-buffer FIFO with registered one-cycle read, registered flags and engine flush.
// Optional sticky overflow/underflow detection is built when INBUF_FIFO_ERR_CHK_EN is defined.
module inbuf_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          eng_rstn,
    inbuf_fifo_if.slave   bus
);
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              empty_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_val_q;
    logic              wr_acc;
    logic              rd_acc;

    assign wr_acc = bus.host_inbuf_wr_en & ~full_q & eng_rstn;
    assign rd_acc = bus.cntl_inbuf_fifo_rd_rq & bus.cntl_inbuf_fifo_mem_en & ~empty_q & eng_rstn;

    always_comb begin
        count_nxt = count_q;
        if (!eng_rstn) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Storage has no reset so it maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.host_inbuf_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rd_data_q <= '0;
            rd_val_q  <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CNT_W'(DEPTH));
            empty_q  <= (count_nxt == '0);
            rd_val_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr];
            end
            if (!eng_rstn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    assign bus.inbuf_host_full        = full_q;
    assign bus.inbuf_fifo_cntl_empty  = empty_q;
    assign bus.inbuf_fifo_count       = count_q;
    assign bus.inbuf_fifo_rd_data     = rd_data_q;
    assign bus.inbuf_fifo_rd_data_val = rd_val_q;

`ifdef INBUF_FIFO_ERR_CHK_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (!eng_rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.host_inbuf_wr_en && full_q) ovf_q <= 1'b1;
            if (bus.cntl_inbuf_fifo_rd_rq && bus.cntl_inbuf_fifo_mem_en && empty_q) udf_q <= 1'b1;
        end
    end

    assign bus.inbuf_fifo_ovf = ovf_q;
    assign bus.inbuf_fifo_udf = udf_q;
`else
    assign bus.inbuf_fifo_ovf = 1'b0;
    assign bus.inbuf_fifo_udf = 1'b0;
`endif

endmodule

// File: doc/inbuf_fifo.md
# inbuf_fifo

Input-buffer FIFO serving the engine's input-buffer controller: the host side pushes data words, and the controller pops them with `cntl_inbuf_fifo_rd_rq` / `cntl_inbuf_fifo_mem_en` while watching `inbuf_fifo_cntl_empty`. It is the responder end of the input-buffer read interface: SRAM-style storage with registered, one-cycle read latency, flow-control flags and a synchronous flush driven by the engine reset. It sits between the host write path and the engine datapath, next to the bitmatrix memory.

## Interface
- `DATA_W`, default 32: data word width (matches `INBUF_MEM_DATA_W`).
- `DEPTH`, default 16: number of entries; must be a power of two, ≥ 2.
- `ADDR_W`, default `$clog2(DEPTH)`: pointer width; derived, do not override.

- `clk`  in  1  the single clock; all logic samples on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `eng_rstn`  in  1  synchronous, active-low flush from the engine FSM.
- `host_inbuf_wr_en`  in  1  write request.
- `host_inbuf_wr_data`  in  DATA_W  write data.
- `inbuf_host_full`  out  1  FIFO full; registered.
- `cntl_inbuf_fifo_rd_rq`  in  1  read request.
- `cntl_inbuf_fifo_mem_en`  in  1  memory enable; a read requires this to be high.
- `inbuf_fifo_cntl_empty`  out  1  FIFO empty; registered.
- `inbuf_fifo_rd_data`  out  DATA_W  read data.
- `inbuf_fifo_rd_data_val`  out  1  one-cycle qualifier for `inbuf_fifo_rd_data`.
- `inbuf_fifo_count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `inbuf_fifo_ovf`  out  1  sticky overflow error.
- `inbuf_fifo_udf`  out  1  sticky underflow error.

## Operation
- **Write accept:** `wr_acc = host_inbuf_wr_en & ~inbuf_host_full & eng_rstn`.
  - Stores `host_inbuf_wr_data` at `wr_ptr`.
  - Advances `wr_ptr` by 1, modulo DEPTH (natural wrap).
- **Read accept:** `rd_acc = cntl_inbuf_fifo_rd_rq & cntl_inbuf_fifo_mem_en & ~inbuf_fifo_cntl_empty & eng_rstn`.
  - Registers `mem[rd_ptr]` into `inbuf_fifo_rd_data`.
  - Advances `rd_ptr` by 1, modulo DEPTH.
- **Count update:**
  - +1 on write accept only.
  - −1 on read accept only.
  - Unchanged when both are accepted in the same cycle.
- **Flags:** `inbuf_fifo_cntl_empty = (count == 0)` and `inbuf_host_full = (count == DEPTH)`, both registered from the next-count value.
- **Full with simultaneous read:** a write is rejected when full, even if a read is accepted in the same cycle. No bypass.
- **Empty with simultaneous write:** a read is rejected when empty, even if a write is accepted in the same cycle. There is no fall-through; data is readable the cycle after the write.
- **Rejected requests:**
  - A rejected write drops its data.
  - A rejected read leaves `inbuf_fifo_rd_data` unchanged, with `inbuf_fifo_rd_data_val` low.
  - Neither moves a pointer.
- **`rd_rq` with `mem_en` low:** not a read and not an error.
- **Flush (`eng_rstn` low at a clock edge):**
  - Clears `wr_ptr`, `rd_ptr` and count; `empty`=1 and `full`=0 from the next cycle.
  - Forces `inbuf_fifo_rd_data_val` to 0 next cycle.
  - Flush wins over any simultaneous read or write.
  - Memory contents are not cleared.
  - `inbuf_fifo_rd_data` holds its value.
- **Reset (`rstn` low):** asynchronous; all state goes to reset values immediately, including mid-operation. Memory contents are undefined.

## Timing
- **Read latency:** one cycle. If `rd_acc` is true in cycle N, then `inbuf_fifo_rd_data` / `inbuf_fifo_rd_data_val` are valid in cycle N+1. Back-to-back reads give one word per cycle.
- **Valid pulse:** `inbuf_fifo_rd_data_val` is high exactly one cycle per accepted read.
- **Write-to-visible latency:** a write in cycle N makes `empty` fall in N+1; the earliest read of that word is in N+1, with data in N+2.
- **`full`:** rises the cycle after the write that fills the FIFO; falls the cycle after an accepted read.
- **Reset values:**
  - `inbuf_fifo_rd_data`=0, `inbuf_fifo_rd_data_val`=0.
  - `inbuf_fifo_cntl_empty`=1, `inbuf_host_full`=0, `inbuf_fifo_count`=0.
  - `inbuf_fifo_ovf`=0, `inbuf_fifo_udf`=0.

## Configuration
- **`INBUF_FIFO_ERR_CHK_EN` defined:**
  - `inbuf_fifo_ovf` sets on any `host_inbuf_wr_en` while full.
  - `inbuf_fifo_udf` sets on any `rd_rq & mem_en` while empty.
  - Both are sticky; cleared only by `rstn` low or a flush.
- **Not defined:** both ports exist but are tied to 0, and no error logic is synthesized. FIFO behaviour is otherwise identical.

## Test plan
- **Fill and drain** (DEPTH=4, `DATA_W`=32): write 0xA0..0xA3 on consecutive cycles.
  - Expect `full`=1 the cycle after the 4th write and count=4.
  - Read 4 back-to-back: `rd_data_val` high 4 consecutive cycles with 0xA0..0xA3 in order, then `empty`=1.
- **Wrap-around:** 10 write/read cycles, one write and one read per cycle after a 1-word prefill.
  - Expect count constant at 1 and data in order across a pointer wrap.
- **Boundaries:**
  - Write 0x55 while full → dropped; count stays 4; with the macro defined, `ovf`=1.
  - Read on empty → no `rd_data_val`; `udf`=1.
  - `rd_rq`=1 with `mem_en`=0 on non-empty → no read, no `udf`.
- **Simultaneous events:**
  - Empty, write 0x11 and read in the same cycle → read rejected; a read one cycle later returns 0x11.
  - Full, read and write in the same cycle → write rejected; count=3.
- **Flush:** with 3 words held and a read accepted in the same cycle as `eng_rstn`=0 → next cycle `rd_data_val`=0, `empty`=1, count=0, `ovf`/`udf` cleared.
- **Async reset mid-burst:** assert `rstn` low between clock edges during back-to-back reads → all outputs reach reset values without waiting for a clock edge.
